// File: rtl/fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_ctrl : fetch/decode sequencer with JMP, BAN, STP and exec handshake |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fetch_ctrl #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [11:0] addr,
  input  logic [15:0] ins,
  input  logic        acc_neg,
  input  logic        exec_done,
  output logic [15:0] ir,
  output logic [11:0] pc,
  output logic        exec_valid,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] c_OP_JMP = 4'b1000;
  localparam logic [3:0] c_OP_BAN = 4'b1001;
  localparam logic [3:0] c_OP_STP = 4'b0100;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_pc;
  logic [11:0] w_pc_nxt;
  logic [15:0] r_ir;
  logic [15:0] w_ir_nxt;
  logic [3:0]  w_op;
  logic [11:0] w_operand;

  assign w_op      = r_ir[15:12];
  assign w_operand = r_ir[11:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_ir_nxt    = ins;
        w_pc_nxt    = r_pc + 12'd1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (w_op)
          c_OP_JMP: begin
            w_pc_nxt    = w_operand;
            w_state_nxt = S_FETCH;
          end
          c_OP_BAN: begin
            // pc already points past the BAN, so back up one to branch relative to it
            if (acc_neg) w_pc_nxt = r_pc - 12'd1 + w_operand;
            w_state_nxt = S_FETCH;
          end
          c_OP_STP: w_state_nxt = S_HALT;
          4'b0000, 4'b0001, 4'b0010, 4'b0011,
          4'b0101, 4'b0110, 4'b0111: w_state_nxt = S_EXEC;
          default: w_state_nxt = S_FETCH;
        endcase
      end
      S_EXEC: begin
        if (exec_done) w_state_nxt = S_FETCH;
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags decode straight from state so async reset clears them at once
  assign exec_valid = (r_state == S_EXEC);
  assign halted     = (r_state == S_HALT);
  assign addr       = r_pc;
  assign pc         = r_pc;
  assign ir         = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// Testbench for fetch_ctrl: instruction-level reference model over a random
// and directed instruction memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] addr;
  logic [15:0] ins;
  logic        acc_neg = 1'b0;
  logic        exec_done = 1'b0;
  logic [15:0] ir;
  logic [11:0] pc;
  logic        exec_valid;
  logic        halted;

  logic [15:0] mem [0:4095];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mpc      = 0;

  assign ins = mem[addr];

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(12'h000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .addr       (addr),
    .ins        (ins),
    .acc_neg    (acc_neg),
    .exec_done  (exec_done),
    .ir         (ir),
    .pc         (pc),
    .exec_valid (exec_valid),
    .halted     (halted)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'hA000;
  endtask

  task automatic reset_and_start();
    start = 1'b0; exec_done = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    mpc = 0;
  endtask

  // Executes one instruction at mpc and checks every observable step.
  // neg_sel/wait_sel < 0 means pick randomly.
  task automatic run_instr(input int neg_sel, input int wait_sel);
    logic [15:0] w;
    int op, operand, nxt, k;
    logic neg;
    w = mem[mpc];
    op = int'(w[15:12]);
    operand = int'(w[11:0]);

    n_checks++;
    if (addr !== 12'(mpc) || exec_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_entry: addr=%0d ev=%0b h=%0b expected addr=%0d ev=0 h=0",
               addr, exec_valid, halted, mpc);
    end
    start = 1'($urandom); exec_done = 1'($urandom); acc_neg = 1'($urandom);
    tick();

    n_checks++;
    if (ir !== w || pc !== 12'((mpc + 1) % 4096)) begin
      n_fail++;
      $display("FAIL fetch_load: ir=%h pc=%0d expected ir=%h pc=%0d",
               ir, pc, w, (mpc + 1) % 4096);
    end
    neg = (neg_sel < 0) ? 1'($urandom) : 1'(neg_sel);
    acc_neg = neg; exec_done = 1'($urandom); start = 1'($urandom);
    tick();
    acc_neg = ~neg;

    if (op == 4) begin
      n_checks++;
      if (halted !== 1'b1 || exec_valid !== 1'b0 || pc !== 12'((mpc + 1) % 4096)) begin
        n_fail++;
        $display("FAIL stp: halted=%0b ev=%0b pc=%0d expected halted=1 ev=0 pc=%0d",
                 halted, exec_valid, pc, (mpc + 1) % 4096);
      end
      mpc = (mpc + 1) % 4096;
    end else if (op <= 7) begin
      n_checks++;
      if (exec_valid !== 1'b1 || ir !== w) begin
        n_fail++;
        $display("FAIL exec_enter: ev=%0b ir=%h expected ev=1 ir=%h", exec_valid, ir, w);
      end
      k = (wait_sel < 0) ? int'($urandom_range(0, 3)) : wait_sel;
      for (int i = 0; i < k; i++) begin
        exec_done = 1'b0;
        tick();
        n_checks++;
        if (exec_valid !== 1'b1 || ir !== w || pc !== 12'((mpc + 1) % 4096)) begin
          n_fail++;
          $display("FAIL exec_hold: ev=%0b ir=%h pc=%0d expected ev=1 ir=%h pc=%0d",
                   exec_valid, ir, pc, w, (mpc + 1) % 4096);
        end
      end
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      mpc = (mpc + 1) % 4096;
      n_checks++;
      if (exec_valid !== 1'b0 || addr !== 12'(mpc)) begin
        n_fail++;
        $display("FAIL exec_leave: ev=%0b addr=%0d expected ev=0 addr=%0d",
                 exec_valid, addr, mpc);
      end
    end else begin
      if (op == 8)             nxt = operand;
      else if (op == 9 && neg) nxt = (mpc + operand) % 4096;
      else                     nxt = (mpc + 1) % 4096;
      n_checks++;
      if (exec_valid !== 1'b0 || halted !== 1'b0 || pc !== 12'(nxt)) begin
        n_fail++;
        $display("FAIL branch_nop: op=%0d ev=%0b h=%0b pc=%0d expected ev=0 h=0 pc=%0d",
                 op, exec_valid, halted, pc, nxt);
      end
      mpc = nxt;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (pc !== 12'h000 || addr !== 12'h000 || ir !== 16'h0000 ||
        exec_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%0d addr=%0d ir=%h ev=%0b h=%0b expected 0,0,0000,0,0",
               pc, addr, ir, exec_valid, halted);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    start = 1'b0; exec_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      acc_neg = 1'($urandom);
      tick();
      n_checks++;
      if (pc !== 12'h000 || ir !== 16'h0000 || exec_valid !== 1'b0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold: pc=%0d ir=%h ev=%0b h=%0b expected 0,0000,0,0",
                 pc, ir, exec_valid, halted);
      end
    end
    exec_done = 1'b0;
  endtask

  task automatic test_directed_program();
    clear_mem();
    mem[0]  = 16'h7000;
    mem[1]  = 16'h8007;
    mem[7]  = 16'h8009;
    mem[9]  = 16'h9002;
    mem[10] = 16'h8009;
    mem[11] = 16'h4000;
    reset_and_start();
    run_instr(0, 1);   // LDA
    run_instr(0, -1);  // JMP 7
    run_instr(0, -1);  // JMP 9
    run_instr(0, -1);  // BAN not taken -> 10
    run_instr(0, -1);  // JMP 9
    run_instr(1, -1);  // BAN taken -> 11
    run_instr(0, -1);  // STP
  endtask

  task automatic test_halt();
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); exec_done = 1'($urandom); acc_neg = 1'($urandom);
      tick();
      n_checks++;
      if (halted !== 1'b1 || exec_valid !== 1'b0 || pc !== 12'd12 || ir !== 16'h4000) begin
        n_fail++;
        $display("FAIL halt_hold: h=%0b ev=%0b pc=%0d ir=%h expected 1,0,12,4000",
                 halted, exec_valid, pc, ir);
      end
    end
    start = 1'b0; exec_done = 1'b0;
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0]    = 16'h8FFE;
    mem[4094] = 16'h0000;
    mem[4095] = 16'h9003;
    mem[2]    = 16'h4000;
    reset_and_start();
    run_instr(0, 0);   // JMP 4094
    run_instr(0, 0);   // CLA
    run_instr(1, 0);   // BAN +3 from 4095 -> 2
    run_instr(0, 0);   // STP
    clear_mem();
    mem[0]    = 16'h8FFF;
    mem[4095] = 16'h2000;
    reset_and_start();
    run_instr(0, 0);   // JMP 4095
    run_instr(0, 2);   // SHR, pc wraps to 0
  endtask

  task automatic test_async_reset();
    clear_mem();
    mem[0] = 16'h5ABC;
    reset_and_start();
    tick();
    tick();
    n_checks++;
    if (exec_valid !== 1'b1 || pc !== 12'd1 || ir !== 16'h5ABC) begin
      n_fail++;
      $display("FAIL pre_reset_exec: ev=%0b pc=%0d ir=%h expected 1,1,5abc", exec_valid, pc, ir);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (exec_valid !== 1'b0 || pc !== 12'h000 || ir !== 16'h0000 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: ev=%0b pc=%0d ir=%h h=%0b expected 0,0,0000,0",
               exec_valid, pc, ir, halted);
    end
    tick();
    rst_n = 1'b1;
    exec_done = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if (exec_valid !== 1'b0 || pc !== 12'h000 || ir !== 16'h0000) begin
        n_fail++;
        $display("FAIL resume_needs_start: ev=%0b pc=%0d ir=%h expected 0,0,0000",
                 exec_valid, pc, ir);
      end
    end
    exec_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mpc = 0;
    run_instr(-1, 0);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 4096; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'h4) w[15:12] = 4'hA;
      mem[i] = w;
    end
    reset_and_start();
    for (int n = 0; n < 300; n++) run_instr(-1, (n % 2 == 0) ? 0 : -1);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_directed_program();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin fetching from IDLE.
REQ-005 SHALL have port addr  output  12  instruction-memory address, combinationally equal to pc.
REQ-006 SHALL have port ins  input  16  instruction word returned combinationally by instruction memory for addr.
REQ-007 SHALL have port acc_neg  input  1  accumulator sign bit (1 = negative), sampled for BAN.
REQ-008 SHALL have port exec_done  input  1  executor finished current instruction.
REQ-009 SHALL have port ir  output  16  instruction register.
REQ-010 SHALL have port pc  output  12  program counter.
REQ-011 SHALL have port exec_valid  output  1  ir holds an instruction for the executor.
REQ-012 SHALL have port halted  output  1  STP reached.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-014 IDLE: start=1 -> FETCH next cycle; start=0 -> stay.
REQ-015 FETCH (1 cycle): ir <= ins, pc <= pc+1 mod 4096 (4095 wraps to 0), -> DECODE.
REQ-016 DECODE (1 cycle) SHALL act on opcode ir[15:12]; operand = ir[11:0].
REQ-017 Opcode 1000 (JMP): pc <= operand, -> FETCH; no exec_valid.
REQ-018 Opcode 1001 (BAN): if acc_neg=1, pc <= (pc-1)+operand mod 4096 (relative to BAN's own address), else pc unchanged; -> FETCH; no exec_valid.
REQ-019 Opcode 0100 (STP): -> HALT; pc unchanged.
REQ-020 Opcodes 0000,0001,0010,0011,0101,0110,0111 (CLA,COM,SHR,CSL,ADD,STA,LDA) -> EXEC; opcodes 1010-1111 treated as no-op -> FETCH.
REQ-021 EXEC: exec_valid=1 and ir stable; exec_done=1 sampled -> FETCH next cycle, exec_valid drops same edge.
REQ-022 exec_done=1 same cycle EXEC entered is not seen until EXEC is active (minimum EXEC length 1 cycle).
REQ-023 exec_valid SHALL be 1 only in EXEC; halted SHALL be 1 only in HALT.
REQ-024 HALT SHALL be left only by reset; start and exec_done ignored.
REQ-025 start outside IDLE and exec_done outside EXEC SHALL be ignored.
REQ-026 acc_neg SHALL be sampled only in DECODE of a BAN.
REQ-027 Minimum instruction cycle: JMP/BAN/no-op 2 cycles; executed instruction 3 cycles + executor wait.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, pc=RESET_PC, ir=16'h0000, exec_valid=0, halted=0, regardless of state.
REQ-029 Reset deassertion mid-program SHALL resume only after a new start pulse, from RESET_PC.

Verification
REQ-030 Reset, start=1 one cycle, ins=16'h7000 at addr 0 -> cycle 2 ir=16'h7000, pc=1; cycle 3 exec_valid=1; exec_done=1 -> next cycle FETCH at addr 1.
REQ-031 ir fetched 16'h8009 (JMP 9) at addr 7 -> after DECODE pc=9, exec_valid never asserted.
REQ-032 16'h9002 (BAN +2) at addr 9, acc_neg=1 -> pc=11; acc_neg=0 -> pc=10.
REQ-033 16'h4000 (STP) at addr 11 -> halted=1, pc=12, exec_valid=0; later start/exec_done pulses -> no change.
REQ-034 pc=4095 with non-branch instruction -> FETCH yields pc=0; BAN at 4095 operand 3, acc_neg=1 -> pc=2.
REQ-035 rst_n=0 pulse during EXEC with exec_valid=1 -> exec_valid=0, pc=0, ir=0 immediately, before next clock edge.
